seq_detect_multi: RTL and testbench

Parametrised multi-pattern serial sequence detector with a registered Mealy-style output. It watches a 1-bit serial stream qualified by a valid strobe and compares the most recent LEN bits against NPAT runtime-programmable patterns. It flags each pattern that matches, supports overlapping and non-overlapping detection, and keeps a saturating match count. It is the generalised successor to the fixed 3-bit two-pattern detectors in the sequential-logic library.

---
 rtl/seq_detect_multi.sv | 142 ++++++++++++++
 tb/tb_seq_detect_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_multi.sv
// ---------------------------------------------------------------------------
// seq_detect_multi
//
// Multi-pattern serial sequence detector. It compares the last LEN accepted
// bits of a 1-bit stream against NPAT runtime-programmable patterns. The
// per-pattern match flags are registered. Overlapping and non-overlapping
// detection are both supported. An optional match counter saturates at its
// maximum value.
//
// Optional feature macro: SEQ_DET_CNT_EN
//   defined   -> match_cnt is a saturating CNT_W-bit counter of cycles with y=1
//   undefined -> match_cnt is tied to 0 and no counter flops exist
//
// Parameters
//   LEN      pattern length in bits (2..16)
//   NPAT     number of patterns (1..4)
//   CNT_W    match counter width (1..16)
//   PAT_INIT reset patterns; pattern i is PAT_INIT[i*LEN +: LEN]. The MSB of
//            each pattern is the first bit received.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   qualifies in
//   in         serial data bit
//   ovl        1 = overlapping detection, 0 = restart after a hit
//   clr        synchronous clear of history, match and counter (patterns kept)
//   pat_we     pattern write strobe (clears history, drops that cycle's bit)
//   pat_idx    pattern slot to write; out-of-range slots are ignored
//   pat_wdata  new pattern value
//   match      registered per-pattern match flags (1-cycle pulses)
//   y          OR of match
//   match_cnt  number of cycles with y set, saturating
// ---------------------------------------------------------------------------
module seq_detect_multi #(
    parameter int LEN   = 3,
    parameter int NPAT  = 2,
    parameter int CNT_W = 8,
    parameter logic [NPAT*LEN-1:0] PAT_INIT = {3'b001, 3'b100}
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic                                  in,
    input  logic                                  ovl,
    input  logic                                  clr,
    input  logic                                  pat_we,
    input  logic [(NPAT > 1 ? $clog2(NPAT) : 1)-1:0] pat_idx,
    input  logic [LEN-1:0]                        pat_wdata,
    output logic [NPAT-1:0]                       match,
    output logic                                  y,
    output logic [CNT_W-1:0]                      match_cnt
);

    localparam int IDX_W  = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam int FILL_W = $clog2(LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

    // Only the newest LEN-1 bits are kept: the oldest bit of a window is
    // shifted out before it could ever be compared again.
    logic [LEN-2:0]  hist_reg;
    logic [FILL_W-1:0] fill_reg;
    logic [NPAT-1:0] match_reg;

    logic [LEN-1:0]  window;
    logic            fill_full;
    logic            accept;
    logic [NPAT-1:0] hit;
    logic            hit_any;

    assign window    = {hist_reg, in};
    assign fill_full = (fill_reg == FILL_MAX);
    // pat_we and clr both take precedence over an incoming bit.
    assign accept    = in_valid & ~pat_we & ~clr;
    assign hit_any   = |hit;

    // Pattern slots and their comparators.
    generate
        for (genvar gi = 0; gi < NPAT; gi++) begin : g_pat
            logic [LEN-1:0] pat_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pat_reg <= PAT_INIT[gi*LEN +: LEN];
                end else if (!clr && pat_we && (pat_idx == IDX_W'(gi))) begin
                    pat_reg <= pat_wdata;
                end
            end

            assign hit[gi] = fill_full && (window == pat_reg);
        end
    endgenerate

    // History, fill level and match flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            match_reg <= '0;
        end else if (clr || pat_we) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            match_reg <= '0;
        end else if (accept) begin
            match_reg <= hit;
            if (!ovl && hit_any) begin
                // Non-overlapping: the next match must be built from fresh bits.
                hist_reg <= '0;
                fill_reg <= '0;
            end else begin
                hist_reg <= window[LEN-2:0];
                if (!fill_full) begin
                    fill_reg <= fill_reg + 1'b1;
                end
            end
        end else begin
            match_reg <= '0;
        end
    end

    assign match = match_reg;
    assign y     = |match_reg;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (accept && hit_any && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign match_cnt = cnt_reg;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_multi.sv
// Testbench for seq_detect_multi: default instance plus a CNT_W=2 instance
// sharing the same stimulus so counter saturation is observable.
module tb_seq_detect_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_b;
    logic       ovl;
    logic       clr;
    logic       pat_we;
    logic       pat_idx;
    logic [2:0] pat_wdata;

    logic [1:0] match_a;
    logic       y_a;
    logic [7:0] cnt_a;
    logic [1:0] match_b;
    logic       y_b;
    logic [1:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_multi u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b), .ovl(ovl),
        .clr(clr), .pat_we(pat_we), .pat_idx(pat_idx), .pat_wdata(pat_wdata),
        .match(match_a), .y(y_a), .match_cnt(cnt_a)
    );

    seq_detect_multi #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b), .ovl(ovl),
        .clr(clr), .pat_we(pat_we), .pat_idx(pat_idx), .pat_wdata(pat_wdata),
        .match(match_b), .y(y_b), .match_cnt(cnt_b)
    );

    // Reference model state
    logic [2:0] m_pat [2];
    logic [2:0] m_hist;
    int         m_nb;
    int         m_cnt8;
    int         m_cnt2;

    typedef struct {
        logic [1:0] m;
        logic [7:0] c8;
        logic [1:0] c2;
        string      tag;
    } exp_t;
    exp_t sb[$];

    function automatic int exp_cnt(input int c);
`ifdef SEQ_DET_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat[0] = 3'b100;
        m_pat[1] = 3'b001;
        m_hist   = 3'b000;
        m_nb     = 0;
        m_cnt8   = 0;
        m_cnt2   = 0;
        sb.delete();
    endtask

    // Drive one cycle, predict its outcome, then check it after the edge.
    task automatic step(input string tag, input logic v, input logic b, input logic o,
                        input logic c, input logic we, input logic idx, input logic [2:0] wd);
        exp_t e;
        logic [2:0] win;
        logic [1:0] em;
        in_valid = v; in_b = b; ovl = o; clr = c; pat_we = we; pat_idx = idx; pat_wdata = wd;
        em = 2'b00;
        if (c) begin
            m_hist = 3'b000; m_nb = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (we) begin
            m_pat[idx] = wd; m_hist = 3'b000; m_nb = 0;
        end else if (v) begin
            win = {m_hist[1:0], b};
            for (int i = 0; i < 2; i++)
                em[i] = (m_nb >= 2) && (win == m_pat[i]);
            if (em != 2'b00) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
            if (!o && em != 2'b00) begin
                m_hist = 3'b000; m_nb = 0;
            end else begin
                m_hist = win; m_nb++;
            end
        end
        e.m = em; e.c8 = 8'(exp_cnt(m_cnt8)); e.c2 = 2'(exp_cnt(m_cnt2)); e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".match"}, 16'(match_a), 16'(e.m));
        chk({e.tag, ".y"}, 16'(y_a), 16'(|e.m));
        chk({e.tag, ".cnt"}, 16'(cnt_a), 16'(e.c8));
        chk({e.tag, ".cnt_sat"}, 16'(cnt_b), 16'(e.c2));
        $display("step %s v=%0b in=%0b ovl=%0b clr=%0b we=%0b -> match=%b cnt=%0d cnt_sat=%0d",
                 tag, v, b, o, c, we, match_a, cnt_a, cnt_b);
    endtask

    task automatic bit_in(input string tag, input logic b, input logic o);
        step(tag, 1'b1, b, o, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, ".match"}, 16'(match_a), 16'h0);
        chk({tag, ".y"}, 16'(y_a), 16'h0);
        chk({tag, ".cnt"}, 16'(cnt_a), 16'h0);
        chk({tag, ".cnt_sat"}, 16'(cnt_b), 16'h0);
        $display("reset %s match=%b cnt=%0d", tag, match_a, cnt_a);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_b = 1'b0; ovl = 1'b1; clr = 1'b0;
        pat_we = 1'b0; pat_idx = 1'b0; pat_wdata = 3'b000;
        model_reset();
        #2;
        chk("rst.match", 16'(match_a), 16'h0);
        chk("rst.y", 16'(y_a), 16'h0);
        chk("rst.cnt", 16'(cnt_a), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Default patterns, overlapping: 1,0,0,1
        bit_in("dflt1", 1'b1, 1'b1);
        bit_in("dflt2", 1'b0, 1'b1);
        bit_in("dflt3", 1'b0, 1'b1);
        bit_in("dflt4", 1'b1, 1'b1);
        step("dflt_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

        // Non-overlap with pat0=101
        step("wr101", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101);
        bit_in("novl1", 1'b1, 1'b0);
        bit_in("novl2", 1'b0, 1'b0);
        bit_in("novl3", 1'b1, 1'b0);
        bit_in("novl4", 1'b0, 1'b0);
        bit_in("novl5", 1'b1, 1'b0);
        step("clr_a", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        bit_in("ovl1", 1'b1, 1'b1);
        bit_in("ovl2", 1'b0, 1'b1);
        bit_in("ovl3", 1'b1, 1'b1);
        bit_in("ovl4", 1'b0, 1'b1);
        bit_in("ovl5", 1'b1, 1'b1);

        // Gapped input with pat0=100 restored
        step("wr100", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100);
        bit_in("gap_b1", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            step("gap_idle", 1'b0, 1'(i), 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        bit_in("gap_b2", 1'b0, 1'b1);
        bit_in("gap_b3", 1'b0, 1'b1);

        // Pattern write colliding with a valid bit (would otherwise complete 110)
        bit_in("col_pre1", 1'b1, 1'b1);
        bit_in("col_pre2", 1'b1, 1'b1);
        step("col_we", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b110);
        bit_in("col1", 1'b1, 1'b1);
        bit_in("col2", 1'b1, 1'b1);
        bit_in("col3", 1'b0, 1'b1);

        // Counter saturation on the CNT_W=2 instance, then clear
        step("wr100b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100);
        step("clr_b", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            bit_in("sat_1", 1'b1, 1'b1);
            bit_in("sat_0a", 1'b0, 1'b1);
            bit_in("sat_0b", 1'b0, 1'b1);
        end
        step("clr_c", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);

        // Reset while match is high, and reset mid-stream
        bit_in("rs_a1", 1'b1, 1'b1);
        bit_in("rs_a2", 1'b0, 1'b1);
        bit_in("rs_a3", 1'b0, 1'b1);
        async_reset("rst_hit");
        bit_in("rs_b1", 1'b1, 1'b1);
        bit_in("rs_b2", 1'b0, 1'b1);
        async_reset("rst_mid");
        bit_in("rs_c0", 1'b0, 1'b1);
        bit_in("rs_c1", 1'b1, 1'b1);
        bit_in("rs_c2", 1'b0, 1'b1);
        bit_in("rs_c3", 1'b0, 1'b1);
        step("end_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
